// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM encoding, requester ids and ROM boundary for the memory bus arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;
  localparam logic ID_CPU = 1'b0;
  localparam logic ID_DMA = 1'b1;
  localparam logic [7:0] ROM_LAST = 8'h7F;
endpackage

// File: rtl/mem_arb_select.sv
// mem_arb_select: CPU-priority winner selection with a DMA starvation counter
module mem_arb_select
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic cpu_req,
  input  logic dma_req,
  input  logic take,
  output logic win
);
  localparam int W = $clog2(STARVE_LIMIT + 2);
  localparam logic [W-1:0] LIMIT = W'(STARVE_LIMIT);
  logic [W-1:0] starve_cnt;
  // DMA wins when the CPU is idle or the CPU has used up its run of grants
  always_comb win = (dma_req && (!cpu_req || starve_cnt == LIMIT)) ? ID_DMA : ID_CPU;
  // count CPU grants taken while DMA waits, saturating at the limit
  always_ff @(posedge clk or posedge rst)
    if (rst) starve_cnt <= '0;
    else if (!dma_req || (take && win == ID_DMA)) starve_cnt <= '0;
    else if (take && starve_cnt != LIMIT) starve_cnt <= starve_cnt + W'(1);
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-requester memory bus arbiter; MEM_ARB_WRITE_PROTECT_EN blocks ROM writes and flags err
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_req,
  input  logic       cpu_write_en,
  input  logic [7:0] cpu_address,
  input  logic [7:0] cpu_data_in,
  output logic       cpu_ack,
  output logic [7:0] cpu_data_out,
  input  logic       dma_req,
  input  logic       dma_write_en,
  input  logic [7:0] dma_address,
  input  logic [7:0] dma_data_in,
  output logic       dma_ack,
  output logic [7:0] dma_data_out,
  output logic [7:0] mem_address,
  output logic [7:0] mem_data_in,
  output logic       mem_write_en,
  input  logic [7:0] mem_data_out,
  output logic       busy,
  output logic       err
);
  state_t state, state_nxt;
  logic take, win, owner, we_q, prot;
  logic [7:0] addr_q, wdata_q, cpu_q, dma_q;
  assign take = state != ADDR && (cpu_req || dma_req);
  mem_arb_select #(.STARVE_LIMIT(STARVE_LIMIT)) u_select (
    .clk(clk),
    .rst(rst),
    .cpu_req(cpu_req),
    .dma_req(dma_req),
    .take(take),
    .win(win)
  );
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // ADDR always advances to DATA; any pending request starts a new access from IDLE or DATA
  always_comb state_nxt = state == ADDR ? DATA : take ? ADDR : IDLE;
  // latch the winner's fields when an access is granted
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      owner   <= ID_CPU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (take) begin
      owner   <= win;
      we_q    <= win ? dma_write_en : cpu_write_en;
      addr_q  <= win ? dma_address : cpu_address;
      wdata_q <= win ? dma_data_in : cpu_data_in;
    end
  // keep each requester's last returned data between its acks
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cpu_q <= '0;
      dma_q <= '0;
    end else if (state == DATA) begin
      if (owner == ID_DMA) dma_q <= mem_data_out;
      else cpu_q <= mem_data_out;
    end
`ifdef MEM_ARB_WRITE_PROTECT_EN
  assign prot = we_q && addr_q <= ROM_LAST;
`else
  assign prot = 1'b0;
`endif
  // bus and completion outputs follow the current phase; data_out shows the live bus during its ack
  always_comb begin
    busy         = state != IDLE;
    mem_address  = state == ADDR ? addr_q : '0;
    mem_data_in  = state == ADDR ? wdata_q : '0;
    mem_write_en = state == ADDR && we_q && !prot;
    cpu_ack      = state == DATA && owner == ID_CPU;
    dma_ack      = state == DATA && owner == ID_DMA;
    cpu_data_out = cpu_ack ? mem_data_out : cpu_q;
    dma_data_out = dma_ack ? mem_data_out : dma_q;
    err          = state == DATA && prot;
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_mem_bus_arbiter;
  localparam int LIMIT = 3;
`ifdef MEM_ARB_WRITE_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic cpu_req, cpu_write_en, cpu_ack, dma_req, dma_write_en, dma_ack;
  logic [7:0] cpu_address, cpu_data_in, cpu_data_out, dma_address, dma_data_in, dma_data_out;
  logic [7:0] mem_address, mem_data_in, mem_data_out;
  logic mem_write_en, busy, err;
  int checks = 0, errors = 0;
  int order[$];
  int m_phase = 0, m_starve = 0;
  bit m_who, m_w, e_ca, e_da, e_pr;
  bit [7:0] m_a, m_d, m_cpu, m_dma;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_write_en(cpu_write_en), .cpu_address(cpu_address),
    .cpu_data_in(cpu_data_in), .cpu_ack(cpu_ack), .cpu_data_out(cpu_data_out),
    .dma_req(dma_req), .dma_write_en(dma_write_en), .dma_address(dma_address),
    .dma_data_in(dma_data_in), .dma_ack(dma_ack), .dma_data_out(dma_data_out),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_write_en(mem_write_en),
    .mem_data_out(mem_data_out), .busy(busy), .err(err)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task model_reset();
    m_phase = 0; m_starve = 0; m_who = 0; m_w = 0;
    m_a = 0; m_d = 0; m_cpu = 0; m_dma = 0;
  endtask

  // one clock of the transaction model: a grant takes two cycles, the bus is free again in the data cycle
  task model_update();
    if (rst) model_reset();
    else begin
      if (m_phase == 2) begin
        if (m_who) m_dma = mem_data_out;
        else m_cpu = mem_data_out;
      end
      if (m_phase != 1 && (cpu_req || dma_req)) begin
        m_who = dma_req && (!cpu_req || m_starve == LIMIT);
        m_w = m_who ? dma_write_en : cpu_write_en;
        m_a = m_who ? dma_address : cpu_address;
        m_d = m_who ? dma_data_in : cpu_data_in;
        m_phase = 1;
        m_starve = (!dma_req || m_who) ? 0 : (m_starve < LIMIT ? m_starve + 1 : LIMIT);
      end else begin
        m_phase = m_phase == 1 ? 2 : 0;
        if (!dma_req) m_starve = 0;
      end
    end
  endtask

  task step();
    @(posedge clk);
    model_update();
    #2;
  endtask

  task new_cpu();
    cpu_req = 1'b1; cpu_write_en = 1'($urandom_range(0, 1));
    cpu_address = 8'($urandom); cpu_data_in = 8'($urandom);
  endtask

  task new_dma();
    dma_req = 1'b1; dma_write_en = 1'($urandom_range(0, 1));
    dma_address = 8'($urandom); dma_data_in = 8'($urandom);
  endtask

  always @(negedge clk) begin
    e_pr = PROT && m_w && m_a <= 8'h7F;
    e_ca = m_phase == 2 && !m_who;
    e_da = m_phase == 2 && m_who;
    check("busy", busy, m_phase != 0);
    check("mem_address", mem_address, m_phase == 1 ? m_a : 8'h00);
    check("mem_data_in", mem_data_in, m_phase == 1 ? m_d : 8'h00);
    check("mem_write_en", mem_write_en, m_phase == 1 && m_w && !e_pr);
    check("err", err, m_phase == 2 && e_pr);
    check("cpu_ack", cpu_ack, e_ca);
    check("dma_ack", dma_ack, e_da);
    check("cpu_data_out", cpu_data_out, e_ca ? mem_data_out : m_cpu);
    check("dma_data_out", dma_data_out, e_da ? mem_data_out : m_dma);
  end

  initial begin
    {cpu_req, cpu_write_en, dma_req, dma_write_en} = '0;
    {cpu_address, cpu_data_in, dma_address, dma_data_in, mem_data_out} = '0;
    repeat (2) step();
    check("rst_busy", busy, 1'b0);
    check("rst_cpu_data", cpu_data_out, 8'h00);
    check("rst_dma_data", dma_data_out, 8'h00);
    rst = 1'b0;
    step(); cpu_req = 1'b1; cpu_address = 8'h10;
    step(); #3;
    check("r26_addr", mem_address, 8'h10);
    check("r26_busy", busy, 1'b1);
    step(); cpu_req = 1'b0; mem_data_out = 8'hA5; #3;
    check("r26_ack", cpu_ack, 1'b1);
    check("r26_data", cpu_data_out, 8'hA5);
    step(); #3;
    check("r26_idle", busy, 1'b0);
    check("r26_hold", cpu_data_out, 8'hA5);
    step(); cpu_req = 1'b1; dma_req = 1'b1; cpu_address = 8'h11; dma_address = 8'h90;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 8) {cpu_req, dma_req} = 2'b00;
      #3;
      if (cpu_ack) order.push_back(0);
      if (dma_ack) order.push_back(1);
      check($sformatf("r27_ack_cycle%0d", i), cpu_ack | dma_ack, i % 2 == 0);
    end
    check("r27_count", 8'(order.size()), 8'd4);
    for (int k = 0; k < 4; k++)
      check($sformatf("r27_grant%0d", k), 8'(k < order.size() ? order[k] : 2), k == 3);
    step(); dma_req = 1'b1; dma_write_en = 1'b1; dma_address = 8'h85; dma_data_in = 8'h3C;
    step(); #3;
    check("r28_we", mem_write_en, 1'b1);
    check("r28_wdata", mem_data_in, 8'h3C);
    check("r28_addr", mem_address, 8'h85);
    step(); dma_req = 1'b0; #3;
    check("r28_dma_ack", dma_ack, 1'b1);
    check("r28_cpu_ack", cpu_ack, 1'b0);
    check("r28_we_off", mem_write_en, 1'b0);
    step(); dma_write_en = 1'b0; cpu_req = 1'b1; cpu_address = 8'h44; cpu_write_en = 1'b0;
    step();
    step(); #1 rst = 1'b1; model_reset(); #1;
    check("r29_busy", busy, 1'b0);
    check("r29_ack", cpu_ack, 1'b0);
    check("r29_cpu_data", cpu_data_out, 8'h00);
    check("r29_dma_data", dma_data_out, 8'h00);
    check("r29_addr", mem_address, 8'h00);
    step(); rst = 1'b0;
    step(); #3;
    check("r29_readdr", mem_address, 8'h44);
    step(); cpu_req = 1'b0; mem_data_out = 8'h77; #3;
    check("r29_reack", cpu_ack, 1'b1);
    check("r29_redata", cpu_data_out, 8'h77);
    step(); cpu_req = 1'b1; cpu_write_en = 1'b1; cpu_address = 8'h20; cpu_data_in = 8'h5A;
    step(); #3;
    check("r30_we", mem_write_en, !PROT);
    check("r30_err_addr", err, 1'b0);
    step(); cpu_req = 1'b0; cpu_write_en = 1'b0; #3;
    check("r30_ack", cpu_ack, 1'b1);
    check("r30_err", err, PROT);
    for (int c = 0; c < 3000; c++) begin
      step();
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 79) == 0) begin
        rst = 1'b1;
        model_reset();
      end
      if (cpu_req && m_phase == 2 && !m_who) begin
        cpu_req = 1'($urandom_range(0, 1));
        if (cpu_req) new_cpu();
      end else if (!cpu_req && $urandom_range(0, 2) == 0) new_cpu();
      if (dma_req && m_phase == 2 && m_who) begin
        dma_req = 1'($urandom_range(0, 1));
        if (dma_req) new_dma();
      end else if (!dma_req && $urandom_range(0, 3) == 0) new_dma();
      mem_data_out = 8'($urandom);
    end
    step(); #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
